mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one simple-dual-port 32-bit BRAM (sync write port, sync read port, byte write mask, 1-cycle read latency) between the core's instruction-fetch port (read-only) and data load/store port (read/write).
- Arbitrates the single BRAM read port and drives the write port.
- Blocks a same-cycle read of an address that is being written.
- Optionally zero-clears the memory after reset before granting any request.

Parameters:
ADDR_WIDTH, 10, word-address width; BRAM depth is 2**ADDR_WIDTH
DATA_WIDTH, 32, word width; fixed at 32 because the byte mask is 4 bits
CLEAR_ON_RESET, 0, 1 = walk all addresses writing zero before entering RUN

Ports:
clock  in  1  single clock for arbiter and BRAM (both BRAM clocks tied to it)
reset  in  1  asynchronous, active-high
init_done  out  1  high in RUN state
i_req_valid  in  1  fetch request
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_WIDTH  fetch word address
i_rsp_valid  out  1  one-cycle pulse, fetch data valid
i_rsp_data  out  DATA_WIDTH  fetch data
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted this cycle
d_req_write  in  1  1 = store, 0 = load
d_req_addr  in  ADDR_WIDTH  data word address
d_req_wdata  in  DATA_WIDTH  store data
d_req_mask  in  4  store byte enables
d_rsp_valid  out  1  one-cycle pulse, load data valid (loads only)
d_rsp_data  out  DATA_WIDTH  load data
mem_write_enable  out  1  to BRAM
mem_read_enable  out  1  to BRAM
mem_mask_write  out  4  to BRAM
mem_addr_write  out  ADDR_WIDTH  to BRAM
mem_addr_read  out  ADDR_WIDTH  to BRAM
mem_data_in  out  DATA_WIDTH  to BRAM
mem_data_out  in  DATA_WIDTH  from BRAM

Behaviour:
- Reset values:
  - state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_addr = 0, last_grant = DATA, rsp_owner = NONE.
  - All ready and rsp_valid outputs = 0. init_done = 0 unless RUN.
- Reset asserted mid-clear or mid-transaction aborts everything. Any pending response is dropped (no rsp_valid).
- FSM:
  - CLEAR:
    - Each cycle: mem_write_enable = 1, mask = 4'hF, data 0, addr = clr_addr; clr_addr increments.
    - On clr_addr = all-ones, go to RUN. Clear takes exactly 2**ADDR_WIDTH cycles.
    - Both ready = 0 throughout.
  - RUN: arbitration is combinational on the current requests.
- Store and read port use:
  - A store (d_req_valid & d_req_write) is always accepted in RUN and drives the write port the same cycle.
  - A store never uses the read port.
- Read-port arbitration between a fetch and a load (d_req_valid & !d_req_write):
  - Only one requester: it is granted.
  - Both request: round-robin. The requester not equal to last_grant wins.
  - last_grant updates only on a cycle where both contended.
- Hazard rule: a fetch with i_req_addr == d_req_addr in the same cycle as an accepted store gets i_req_ready = 0. It retries next cycle, when it reads the new data.
- Ready = grant. A handshake occurs when valid & ready. mem_read_enable = 1 only on a granted read.
- Latency:
  - A read granted on edge N produces rsp_valid to the owner for exactly cycle N+1, with rsp_data = mem_data_out.
  - rsp_owner is registered at N.
  - No response backpressure: requesters must accept.
- Throughput:
  - One read per cycle; back-to-back grants are allowed.
  - A store and a fetch can complete in the same cycle (different addresses).
- Outputs when not valid:
  - i_rsp_data / d_rsp_data mirror mem_data_out and are don't-care when not valid.
  - mem_* outputs are don't-care when their enable is 0; they are driven 0 in the implementation.

Decomposition:
- Package mem_arbiter_pkg:
  - state_t {CLEAR, RUN}
  - owner_t {NONE, FETCH, DATA}
  - BYTE_MASK_ALL = 4'hF
- Sub-module arb_rr2: 2-requester round-robin, last-grant register, update-on-contention input.
- Hazard compare, FSM and clear counter stay in mem_arbiter.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_WIDTH=4: release reset. Expect:
  - 16 writes of 0 to addresses 0..15.
  - init_done rises on cycle 16.
  - Readys stay 0 until then.
  - A later fetch of addr 5 returns 0.
- Store addr 3, data 32'hDEADBEEF, mask 4'b0101, over a prior value of 0. Then load addr 3: d_rsp_valid one cycle after grant with data 32'h00AD00EF.
- Fetch and load both valid for 4 cycles at addrs 1 and 2 (last_grant=DATA after reset). Expect grants FETCH, DATA, FETCH, DATA and rsp_valid pulses one cycle after each grant.
- Store addr 7 (data 32'h12345678) and fetch addr 7 in the same cycle:
  - Expect i_req_ready = 0 that cycle and the store accepted.
  - Next cycle the fetch is granted; i_rsp_data = 32'h12345678.
- Store addr 8 and fetch addr 9 in the same cycle: both accepted. The fetch response follows next cycle with the old addr-9 data.
- Assert reset the cycle after a load grant: no d_rsp_valid pulse. Asserting reset mid-CLEAR restarts clr_addr at 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data BRAM arbiter.
// Holds FSM states, response owners and mask constants.
package mem_arbiter_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    FETCH,
    DATA
  } owner_t;

  localparam logic [3:0] BYTE_MASK_ALL = 4'hF;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin arbiter.
// Requester a is fetch, requester b is data load.
module arb_rr2 (
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic grant_a,
  output logic grant_b
);

  // 1 = requester a won the most recent contention
  logic last_a;

  assign grant_a = req_a & (!req_b | !last_a);
  assign grant_b = req_b & (!req_a | last_a);

  // remember the winner only when both contended
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_a <= 1'b0;
    end else if (update) begin
      last_a <= grant_a;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one simple-dual-port BRAM between fetch and data ports.
// Optional zero-clear walk runs before any request is granted.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  init_done,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_write,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic [3:0]            d_req_mask,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic [3:0]            mem_mask_write,
  output logic [ADDR_WIDTH-1:0] mem_addr_write,
  output logic [ADDR_WIDTH-1:0] mem_addr_read,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  state_t                state;
  owner_t                rsp_owner;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic run;
  logic store;
  logic load;
  logic hazard;
  logic fetch_req;
  logic grant_fetch;
  logic grant_data;

  assign run   = (state == RUN);
  assign store = run & d_req_valid & d_req_write;
  assign load  = run & d_req_valid & !d_req_write;

  // a fetch colliding with a same-cycle store waits one cycle
  // so it reads the freshly written word
  assign hazard    = store & (i_req_addr == d_req_addr);
  assign fetch_req = run & i_req_valid & !hazard;

  arb_rr2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req_a   (fetch_req),
    .req_b   (load),
    .update  (fetch_req & load),
    .grant_a (grant_fetch),
    .grant_b (grant_data)
  );

  assign init_done   = run;
  assign i_req_ready = grant_fetch;
  assign d_req_ready = store | grant_data;

  assign mem_read_enable = grant_fetch | grant_data;
  assign mem_addr_read   = grant_fetch ? i_req_addr :
                           grant_data  ? d_req_addr : '0;

  assign i_rsp_valid = (rsp_owner == FETCH);
  assign d_rsp_valid = (rsp_owner == DATA);
  assign i_rsp_data  = mem_data_out;
  assign d_rsp_data  = mem_data_out;

  // write port: clear walk, store, or idle
  always_comb begin
    mem_write_enable = 1'b0;
    mem_mask_write   = 4'h0;
    mem_addr_write   = '0;
    mem_data_in      = '0;
    if (!run) begin
      mem_write_enable = 1'b1;
      mem_mask_write   = BYTE_MASK_ALL;
      mem_addr_write   = clr_addr;
    end else if (store) begin
      mem_write_enable = 1'b1;
      mem_mask_write   = d_req_mask;
      mem_addr_write   = d_req_addr;
      mem_data_in      = d_req_wdata;
    end
  end

  // FSM, clear counter and response owner
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_addr  <= '0;
      rsp_owner <= NONE;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_addr  <= clr_addr + 1'b1;
          rsp_owner <= NONE;
          if (&clr_addr) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (grant_fetch) begin
            rsp_owner <= FETCH;
          end else if (grant_data) begin
            rsp_owner <= DATA;
          end else begin
            rsp_owner <= NONE;
          end
        end
        default: begin
          state     <= RUN;
          rsp_owner <= NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural BRAM.
// Expected responses are queued at handshake, popped by a monitor.
module tb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          init_done;
  logic          i_req_valid = 1'b0;
  logic          i_req_ready;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic          d_req_write = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic [DW-1:0] d_req_wdata = '0;
  logic [3:0]    d_req_mask = '0;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          mem_write_enable;
  logic          mem_read_enable;
  logic [3:0]    mem_mask_write;
  logic [AW-1:0] mem_addr_write;
  logic [AW-1:0] mem_addr_read;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_d[$];

  mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .init_done        (init_done),
    .i_req_valid      (i_req_valid),
    .i_req_ready      (i_req_ready),
    .i_req_addr       (i_req_addr),
    .i_rsp_valid      (i_rsp_valid),
    .i_rsp_data       (i_rsp_data),
    .d_req_valid      (d_req_valid),
    .d_req_ready      (d_req_ready),
    .d_req_write      (d_req_write),
    .d_req_addr       (d_req_addr),
    .d_req_wdata      (d_req_wdata),
    .d_req_mask       (d_req_mask),
    .d_rsp_valid      (d_rsp_valid),
    .d_rsp_data       (d_rsp_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_mask_write   (mem_mask_write),
    .mem_addr_write   (mem_addr_write),
    .mem_addr_read    (mem_addr_read),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out)
  );

  always #5 clock = ~clock;

  // BRAM model, pre-filled with garbage so the clear walk is visible
  logic [DW-1:0] ram [16];
  logic          filled = 1'b0;
  always @(posedge clock) begin
    if (!filled) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'hA5A50000 | 32'(i);
      filled <= 1'b1;
    end else if (mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask_write[b])
          ram[mem_addr_write][8*b+:8] <= mem_data_in[8*b+:8];
    end
    if (mem_read_enable) mem_data_out <= ram[mem_addr_read];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // response monitor
  always @(negedge clock) begin
    if (i_rsp_valid) begin
      if (exp_i.size() == 0) begin
        chk("unexpected i_rsp_valid", 32'd1, 32'd0);
      end else begin
        chk("i_rsp_data", i_rsp_data, exp_i.pop_front());
      end
    end
    if (d_rsp_valid) begin
      if (exp_d.size() == 0) begin
        chk("unexpected d_rsp_valid", 32'd1, 32'd0);
      end else begin
        chk("d_rsp_data", d_rsp_data, exp_d.pop_front());
      end
    end
  end

  // one cycle of stimulus; entered and left at posedge+1
  task automatic step(input logic iv, input logic [3:0] ia,
                      input logic dv, input logic dw,
                      input logic [3:0] da, input logic [31:0] wd,
                      input logic [3:0] mk, input logic eir,
                      input logic edr, input logic [31:0] eid,
                      input logic [31:0] edd, input string tag);
    i_req_valid = iv;
    i_req_addr  = ia;
    d_req_valid = dv;
    d_req_write = dw;
    d_req_addr  = da;
    d_req_wdata = wd;
    d_req_mask  = mk;
    @(negedge clock);
    chk({tag, " i_req_ready"}, 32'(i_req_ready), 32'(eir));
    chk({tag, " d_req_ready"}, 32'(d_req_ready), 32'(edr));
    #1;
    if (i_req_valid && i_req_ready) exp_i.push_back(eid);
    if (d_req_valid && !d_req_write && d_req_ready) exp_d.push_back(edd);
    @(posedge clock);
    #1;
  endtask

  // clear walk with both requesters waiting; entered at posedge+1
  task automatic run_clear(input string tag);
    i_req_valid = 1'b1;
    i_req_addr  = 4'd5;
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 4'd2;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      chk({tag, " clr we"}, 32'(mem_write_enable), 32'd1);
      chk({tag, " clr addr"}, 32'(mem_addr_write), 32'(k));
      chk({tag, " clr data"}, mem_data_in, 32'd0);
      chk({tag, " clr mask"}, 32'(mem_mask_write), 32'hF);
      chk({tag, " clr readys"}, 32'({i_req_ready, d_req_ready}), 32'd0);
      chk({tag, " clr init_done"}, 32'(init_done), 32'd0);
      @(posedge clock);
      #1;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(negedge clock);
    chk({tag, " init_done"}, 32'(init_done), 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset readys", 32'({i_req_ready, d_req_ready}), 32'd0);
    chk("reset rsp_valid", 32'({i_rsp_valid, d_rsp_valid}), 32'd0);
    chk("reset init_done", 32'(init_done), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_clear("first");

    step(1, 5, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, "fetch5");
    step(0, 0, 1, 1, 3, 32'hDEADBEEF, 4'b0101, 0, 1, 0, 0, "st3");
    step(0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 32'h00AD00EF, "ld3");
    step(0, 0, 1, 1, 1, 32'h11111111, 4'hF, 0, 1, 0, 0, "st1");
    step(0, 0, 1, 1, 2, 32'h22222222, 4'hF, 0, 1, 0, 0, "st2");
    step(0, 0, 1, 1, 9, 32'h99990000, 4'hF, 0, 1, 0, 0, "st9");

    step(1, 1, 1, 0, 2, 0, 0, 1, 0, 32'h11111111, 0, "rr0");
    step(1, 1, 1, 0, 2, 0, 0, 0, 1, 0, 32'h22222222, "rr1");
    step(1, 1, 1, 0, 2, 0, 0, 1, 0, 32'h11111111, 0, "rr2");
    step(1, 1, 1, 0, 2, 0, 0, 0, 1, 0, 32'h22222222, "rr3");

    step(1, 7, 1, 1, 7, 32'h12345678, 4'hF, 0, 1, 0, 0, "haz");
    step(1, 7, 0, 0, 0, 0, 0, 1, 0, 32'h12345678, 0, "haz retry");

    step(1, 9, 1, 1, 8, 32'h88888888, 4'hF, 1, 1,
         32'h99990000, 0, "st8 f9");
    step(0, 0, 1, 0, 8, 0, 0, 0, 1, 0, 32'h88888888, "ld8");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

    // reset during a granted load drops the response
    d_req_valid = 1'b1;
    d_req_write = 1'b0;
    d_req_addr  = 4'd3;
    @(negedge clock);
    chk("abort d_req_ready", 32'(d_req_ready), 32'd1);
    #1;
    reset = 1'b1;
    d_req_valid = 1'b0;
    @(negedge clock);
    chk("abort d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("abort init_done", 32'(init_done), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // partial clear, then reset restarts the walk at 0
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("partial clr addr", 32'(mem_addr_write), 32'(k));
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_clear("second");

    step(1, 3, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, "fetch3 cleared");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle3");

    chk("exp_i drained", 32'(exp_i.size()), 32'd0);
    chk("exp_d drained", 32'(exp_d.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
